// File: rtl/alu_exec_unit.sv
// Execute-stage unit: ALU-control decode, combinational ALU and an iterative
// multiply/divide engine that owns the HI/LO registers.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             issue,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int M  = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic             neg_main;
  logic             neg_rem;
  logic             div0;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ov_add;
  logic             ov_sub;
  logic             slt;
  logic             sltu;

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    ov_add = (a[M] == b[M]) && (sum[M] != a[M]);
    ov_sub = (a[M] != b[M]) && (diff[M] != a[M]);
    slt    = diff[M] ^ ov_sub;
    sltu   = a < b;
  end

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op)
      2'b00: result = a | b;
      2'b01: begin
        result   = diff;
        overflow = ov_sub;
      end
      2'b11: begin
        result   = sum;
        overflow = ov_add;
      end
      default: begin
        case (funct)
          F_ADDU: result = sum;
          F_SUB: begin
            result   = diff;
            overflow = ov_sub;
          end
          F_SUBU: result = diff;
          F_AND:  result = a & b;
          F_OR:   result = a | b;
          F_XOR:  result = a ^ b;
          F_NOR:  result = ~(a | b);
          F_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
          F_SLTU: result = {{(WIDTH-1){1'b0}}, sltu};
          F_SLL:  result = b << shamt;
          F_SRL:  result = b >> shamt;
          F_SRA:  result = $signed(b) >>> shamt;
          F_MFHI: result = hi;
          F_MFLO: result = lo;
          F_MULT, F_MULTU, F_DIV, F_DIVU: result = '0;
          default: begin
            // F_ADD and every undefined funct
            result   = sum;
            overflow = ov_add;
          end
        endcase
      end
    endcase
  end

  assign zero = (result == '0);
  assign busy = (state != S_IDLE);

  logic             is_md;
  logic             start;
  logic             op_signed;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    is_md     = (funct[5:2] == 4'b0110);
    start     = issue && (alu_op == 2'b10) && is_md && (state == S_IDLE);
    op_signed = !funct[0];
    a_abs     = (op_signed && a[M]) ? -a : a;
    b_abs     = (op_signed && b[M]) ? -b : b;
  end

  // Iteration datapath: acc_hi:acc_lo is the running product for multiply,
  // and remainder:dividend-shifting-into-quotient for restoring divide.
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  always_comb begin
    msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    rem_sh = {acc_hi, acc_lo[M]};
    trial  = rem_sh - {1'b0, opb};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Division by zero leaves remainder = |a|, so the dividend-sign fix
  // restores a exactly; only the quotient needs forcing.
  always_comb begin
    prod_fix = neg_main ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    q_fix    = div0 ? '1 : (neg_main ? -acc_lo : acc_lo);
    r_fix    = neg_rem ? -acc_hi : acc_hi;
    fix_hi   = op_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = op_div ? q_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div0     <= 1'b0;
      opb      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            cnt      <= CW'(WIDTH);
            op_div   <= funct[1];
            neg_main <= op_signed && (a[M] ^ b[M]);
            neg_rem  <= op_signed && a[M];
            div0     <= funct[1] && (b == '0);
            opb      <= b_abs;
            acc_hi   <= '0;
            acc_lo   <= a_abs;
          end
        end
        S_RUN: begin
          if (op_div) begin
            if (!trial[WIDTH]) begin
              acc_hi <= trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= rem_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= msum[WIDTH:1];
            acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=32): directed combinational
// table plus a scoreboard of expected HI/LO for the mult/div engine.
module tb_alu_exec_unit;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        issue;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_t;
  md_t sb[$];

  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .shamt(shamt), .issue(issue), .result(result), .zero(zero),
    .overflow(overflow), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    int sx;
    int sy;
    longint p;
    logic [63:0] ux;
    logic [63:0] uy;
    sx = x;
    sy = y;
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (f)
      F_MULT: begin
        p = longint'(sx) * longint'(sy);
        return p;
      end
      F_MULTU: return ux * uy;
      F_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
    endcase
  endfunction

  // Drives one issue cycle and returns at the sample point of cycle 1.
  task automatic issue_md(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
    md_t e;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
    alu_op = 2'b10;
    funct  = f;
    a      = x;
    b      = y;
    issue  = 1'b1;
    @(negedge clk);
    issue  = 1'b0;
    alu_op = 2'b00;
    funct  = 6'h00;
  endtask

  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (done !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic take(output md_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else begin
      e.hi = 'x;
      e.lo = 'x;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; issue = 1'b1; alu_op = 2'b10; funct = F_MULT;
    a = 32'd5; b = 32'd6; shamt = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b0; issue = 1'b0; alu_op = 2'b00;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_nostart busy got %b want 0", busy); end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        z;
    logic        ov;
  } comb_t;

  task automatic test_comb();
    comb_t tbl[15];
    tbl[0]  = '{2'b01, 6'h00,     32'd5,          32'd5,          5'd0,  32'd0,          1'b1, 1'b0};
    tbl[1]  = '{2'b10, 6'b100000, 32'h7FFFFFFF,   32'd1,          5'd0,  32'h80000000,   1'b0, 1'b1};
    tbl[2]  = '{2'b10, 6'b101010, 32'hFFFFFFFF,   32'd1,          5'd0,  32'd1,          1'b0, 1'b0};
    tbl[3]  = '{2'b10, 6'b101011, 32'hFFFFFFFF,   32'd1,          5'd0,  32'd0,          1'b1, 1'b0};
    tbl[4]  = '{2'b10, F_SRA,     32'd0,          32'h80000000,   5'd4,  32'hF8000000,   1'b0, 1'b0};
    tbl[5]  = '{2'b00, 6'h00,     32'h000000F0,   32'h0000000F,   5'd0,  32'h000000FF,   1'b0, 1'b0};
    tbl[6]  = '{2'b10, 6'b111111, 32'd3,          32'd4,          5'd0,  32'd7,          1'b0, 1'b0};
    tbl[7]  = '{2'b10, 6'b100001, 32'h7FFFFFFF,   32'd1,          5'd0,  32'h80000000,   1'b0, 1'b0};
    tbl[8]  = '{2'b10, 6'b100010, 32'h80000000,   32'd1,          5'd0,  32'h7FFFFFFF,   1'b0, 1'b1};
    tbl[9]  = '{2'b10, F_SLL,     32'd0,          32'd1,          5'd31, 32'h80000000,   1'b0, 1'b0};
    tbl[10] = '{2'b10, F_SRL,     32'd0,          32'h80000000,   5'd31, 32'd1,          1'b0, 1'b0};
    tbl[11] = '{2'b10, 6'b100111, 32'd0,          32'd0,          5'd0,  32'hFFFFFFFF,   1'b0, 1'b0};
    tbl[12] = '{2'b10, F_MULT,    32'd9,          32'd9,          5'd0,  32'd0,          1'b1, 1'b0};
    tbl[13] = '{2'b10, 6'b101010, 32'h80000000,   32'd1,          5'd0,  32'd1,          1'b0, 1'b0};
    tbl[14] = '{2'b11, 6'h00,     32'd2,          32'd3,          5'd0,  32'd5,          1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      issue = 1'b0; alu_op = tbl[i].op; funct = tbl[i].f;
      a = tbl[i].x; b = tbl[i].y; shamt = tbl[i].sh;
      #1;
      checks++; if (result !== tbl[i].r) begin errors++; $display("FAIL comb_result[%0d] got %h want %h", i, result, tbl[i].r); end
      checks++; if (zero !== tbl[i].z) begin errors++; $display("FAIL comb_zero[%0d] got %b want %b", i, zero, tbl[i].z); end
      checks++; if (overflow !== tbl[i].ov) begin errors++; $display("FAIL comb_overflow[%0d] got %b want %b", i, overflow, tbl[i].ov); end
    end
    @(negedge clk);
    alu_op = 2'b00; shamt = '0;
  endtask

  task automatic test_mult();
    md_t e;
    bit ok;
    int badc = 0;
    issue_md(F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) badc++;
      @(negedge clk);
    end
    checks++; if (badc != 0) begin errors++; $display("FAIL mult_busy_window bad cycles %0d want 0", badc); end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL mult_cycle34 busy/done got %b/%b want 0/1", busy, done); end
    take(e, ok);
    checks++; if (!ok || hi !== e.hi) begin errors++; $display("FAIL mult_hi got %h want %h", hi, e.hi); end
    checks++; if (!ok || lo !== e.lo) begin errors++; $display("FAIL mult_lo got %h want %h", lo, e.lo); end
    cur_hi = e.hi; cur_lo = e.lo;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", done); end
    alu_op = 2'b10; funct = F_MFHI; #1;
    checks++; if (result !== cur_hi) begin errors++; $display("FAIL mfhi got %h want %h", result, cur_hi); end
    funct = F_MFLO; #1;
    checks++; if (result !== cur_lo) begin errors++; $display("FAIL mflo got %h want %h", result, cur_lo); end
    alu_op = 2'b00;
  endtask

  task automatic test_divide();
    logic [5:0]  f[4]  = '{F_DIVU, F_DIV, F_DIV, F_DIV};
    logic [31:0] x[4]  = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd5};
    logic [31:0] y[4]  = '{32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
    logic [31:0] eh[4] = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'd5};
    logic [31:0] el[4] = '{32'd14, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    md_t e;
    bit ok;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue_md(f[i], x[i], y[i], eh[i], el[i]);
      wait_done(1, cyc);
      checks++; if (cyc != 34) begin errors++; $display("FAIL div_latency[%0d] got %0d want 34", i, cyc); end
      take(e, ok);
      checks++; if (!ok || hi !== e.hi) begin errors++; $display("FAIL div_hi[%0d] got %h want %h", i, hi, e.hi); end
      checks++; if (!ok || lo !== e.lo) begin errors++; $display("FAIL div_lo[%0d] got %h want %h", i, lo, e.lo); end
      cur_hi = e.hi; cur_lo = e.lo;
    end
  endtask

  task automatic test_busy();
    md_t e;
    bit ok;
    int cyc;
    logic [63:0] m;
    logic [31:0] old_hi;
    old_hi = cur_hi;
    m = md_model(F_MULT, 32'h00012345, 32'hFFFF6789);
    @(negedge clk);
    issue_md(F_MULT, 32'h00012345, 32'hFFFF6789, m[63:32], m[31:0]);
    repeat (4) @(negedge clk);
    alu_op = 2'b10; funct = F_DIVU; a = 32'd100; b = 32'd7; issue = 1'b1;
    @(negedge clk);
    issue = 1'b0; alu_op = 2'b00;
    repeat (4) @(negedge clk);
    alu_op = 2'b10; funct = F_MFHI; #1;
    checks++; if (result !== old_hi) begin errors++; $display("FAIL busy_mfhi got %h want %h", result, old_hi); end
    wait_done(10, cyc);
    checks++; if (cyc != 34) begin errors++; $display("FAIL busy_latency got %0d want 34", cyc); end
    take(e, ok);
    checks++; if (!ok || hi !== e.hi) begin errors++; $display("FAIL busy_hi got %h want %h", hi, e.hi); end
    checks++; if (!ok || lo !== e.lo) begin errors++; $display("FAIL busy_lo got %h want %h", lo, e.lo); end
    cur_hi = e.hi; cur_lo = e.lo;
    alu_op = 2'b00;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignored_start busy got %b want 0", busy); end
  endtask

  task automatic test_midop_reset();
    md_t e;
    bit ok;
    int cyc;
    int pulses = 0;
    logic [63:0] m;
    m = md_model(F_MULT, 32'd1234, 32'd5678);
    issue_md(F_MULT, 32'd1234, 32'd5678, m[63:32], m[31:0]);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    cur_hi = '0; cur_lo = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo got %h/%h want 0/0", hi, lo); end
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midreset_done pulses %0d want 0", pulses); end
    m = md_model(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue_md(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, m[63:32], m[31:0]);
    wait_done(1, cyc);
    checks++; if (cyc != 34) begin errors++; $display("FAIL postreset_latency got %0d want 34", cyc); end
    take(e, ok);
    checks++; if (!ok || hi !== e.hi) begin errors++; $display("FAIL postreset_hi got %h want %h", hi, e.hi); end
    checks++; if (!ok || lo !== e.lo) begin errors++; $display("FAIL postreset_lo got %h want %h", lo, e.lo); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    md_t e;
    bit ok;
    int cyc;
    logic [63:0] m;
    logic [5:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      f = ops[$urandom_range(0, 3)];
      x = $urandom;
      y = (i == 3) ? 32'd0 : $urandom;
      m = md_model(f, x, y);
      issue_md(f, x, y, m[63:32], m[31:0]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] busy got %b want 1", i, busy); end
      wait_done(1, cyc);
      checks++; if (cyc != 34) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 34", i, cyc); end
      take(e, ok);
      checks++; if (!ok || hi !== e.hi) begin errors++; $display("FAIL b2b_hi[%0d] got %h want %h", i, hi, e.hi); end
      checks++; if (!ok || lo !== e.lo) begin errors++; $display("FAIL b2b_lo[%0d] got %h want %h", i, lo, e.lo); end
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_mult();
    test_divide();
    test_busy();
    test_midop_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage unit for the MIPS datapath. It merges ALU-control decode (`alu_op` plus `funct`) with a WIDTH-bit combinational ALU and an iterative multiply/divide engine that writes HI/LO. Single-cycle ops produce `result` in the same cycle. MULT/MULTU/DIV/DIVU run as a multi-cycle state machine, and `busy` stalls the core while they execute.

## Interface
- `WIDTH`, default 32: datapath width. Must be a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): width of the shift amount.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `alu_op`: input, 2 bits. 00 OR, 01 SUB, 10 R-type (decode `funct`), 11 ADD.
- `funct`: input, 6 bits. R-type function field.
- `a`: input, WIDTH bits. Operand rs.
- `b`: input, WIDTH bits. Operand rt or immediate.
- `shamt`: input, SHW bits. Shift amount.
- `issue`: input, 1 bit. Instruction valid this cycle. Qualifies starting a mult/div.
- `result`: output, WIDTH bits. Combinational result.
- `zero`: output, 1 bit. High when `result` == 0.
- `overflow`: output, 1 bit. Signed overflow for ADD/SUB only; 0 for every other op.
- `busy`: output, 1 bit. Mult/div in progress.
- `done`: output, 1 bit. One-cycle pulse when HI/LO receive a new value.
- `hi`: output, WIDTH bits. HI register.
- `lo`: output, WIDTH bits. LO register.

## Operation
- **R-type decode:**
  - ADD 100000 and ADDU 100001 add; SUB 100010 and SUBU 100011 subtract. Only ADD/SUB drive `overflow`.
  - Logic: AND 100100, OR 100101, XOR 100110, NOR 100111.
  - Compare: SLT 101010 (signed), SLTU 101011 (unsigned). Result is 1 or 0.
  - Shifts of `b` by `shamt`: SLL 000000, SRL 000010, SRA 000011 (arithmetic).
  - MFHI 010000 returns `hi`; MFLO 010010 returns `lo`.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011 start the engine. `result` = 0 for these.
  - Any other `funct` decodes as ADD.
- **Engine start:** the engine starts when `issue`=1, `alu_op`=10, funct ∈ {MULT, MULTU, DIV, DIVU}, state is IDLE and `reset`=0.
  - Signed ops capture the absolute values of the operands and record the sign of the result.
- **FSM states:**
  - IDLE → RUN on start; the cycle counter is loaded with WIDTH.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle. → FIX when the counter reaches 0.
  - FIX: apply the sign correction, write HI/LO, pulse `done`. → IDLE.
- **Multiply:** 2·WIDTH-bit product. HI gets the upper half, LO the lower half.
- **Divide:**
  - LO = quotient, truncated toward zero. HI = remainder, taking the dividend's sign.
  - Divide by zero: LO = all ones, HI = `a`.
  - Signed most-negative ÷ −1: LO = most-negative, HI = 0.
- **Issue while busy:** a mult/div start is ignored. It does not restart the engine or update its operands.
  - Combinational ops still evaluate normally. The core must stall on `busy`.
- **MFHI/MFLO while busy:** return the old HI/LO value.

## Timing
- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM=IDLE.
  - `reset` has priority over `issue` in the same cycle.
- **Mid-operation reset:** aborts the operation and clears HI/LO. No `done` pulse occurs.
- **Combinational outputs:** `result`, `zero` and `overflow` have zero-cycle latency.
- **Engine cycle numbering:** the issue edge is cycle 0.
  - `busy`=1 in cycles 1 through WIDTH+1 (RUN for WIDTH cycles, then FIX).
  - In cycle WIDTH+2: `busy`=0, `done`=1 for exactly one cycle, and `hi`/`lo` hold the new value.
  - Total latency is WIDTH+2 cycles.
- **Back-to-back operations:** a new start is accepted in cycle WIDTH+2, the same cycle as `done`.
- **Width rules:**
  - Shifts use all SHW bits of `shamt`.
  - SLT is computed from the sign and overflow of the subtraction, not from a raw compare.
  - ADDU/SUBU wrap modulo 2^WIDTH.

## Test plan
Bench uses WIDTH=32.
1. **Reset:** hold `reset` for 2 cycles with `issue`=1 and funct MULT → `busy`=0, `done`=0, `hi`=0, `lo`=0; no start occurs.
2. **Signed multiply:** MULT a=0xFFFFFFFD, b=7 → `busy` high for cycles 1–33; `done` in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
3. **Division:**
   - DIVU 100/7 → LO=14, HI=2.
   - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIV 5/0 → LO=0xFFFFFFFF, HI=5.
   - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
4. **Combinational ops:**
   - SUB 5−5 → `zero`=1.
   - ADD 0x7FFFFFFF+1 → 0x80000000, `overflow`=1.
   - SLT −1<1 → 1; SLTU same operands → 0.
   - SRA 0x80000000 by 4 → 0xF8000000.
   - alu_op 00 with 0xF0 and 0x0F → 0xFF.
   - funct 111111 → ADD.
5. **Busy behaviour:**
   - DIVU issued in cycle 5 of a MULT → ignored; MULT result is correct at cycle 34.
   - MFHI in cycle 10 → old HI.
6. **Mid-operation reset:** reset in cycle 10 of a MULT → `busy`=0 the next cycle, HI=LO=0, no `done` pulse.
   - A new MULT issued after reset completes normally.
